// File: rtl/hs_elastic_buffer_pkg.sv
// Shared handshake constants and types for the elastic req/ack buffer
// and the bench producer/consumer models.
package hs_elastic_buffer_pkg;

    // Every ack is a single-cycle pulse, followed by at least one idle cycle.
    localparam int unsigned AckPulseWidth = 1;
    localparam int unsigned MinAckGap     = 1;

    typedef enum logic {
        DnIdle,
        DnAck
    } dn_state_e;

endpackage

// File: rtl/hs_elastic_buffer_if.sv
// Handshake and status bundle between an arf output port, the elastic
// buffer, and the downstream consumer.
interface hs_elastic_buffer_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4
);
    localparam int unsigned LevelWidth = $clog2(Depth) + 1;

    logic                  up_req;
    logic                  up_ack;
    logic [DataWidth-1:0]  up_din;
    logic                  dn_req;
    logic                  dn_ack;
    logic [DataWidth-1:0]  dn_dout;
    logic [LevelWidth-1:0] level;
    logic                  overflow;
    logic [31:0]           in_count;
    logic [31:0]           out_count;

    modport master (
        output up_req, dn_ack, dn_dout, level, overflow, in_count, out_count,
        input  up_ack, up_din, dn_req
    );

    modport slave (
        input  up_req, dn_ack, dn_dout, level, overflow, in_count, out_count,
        output up_ack, up_din, dn_req
    );
endinterface

// File: rtl/hs_fifo_mem.sv
// Storage array with wrapping pointers, occupancy and full/empty flags.
// Callers must not push when full or pop when empty.
module hs_fifo_mem #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic [AddrWidth:0]   level_o,
    output logic [AddrWidth:0]   level_next_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam logic [AddrWidth:0] FullLevel = (AddrWidth + 1)'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [AddrWidth-1:0] wp_q, wp_d;
    logic [AddrWidth-1:0] rp_q, rp_d;
    logic [AddrWidth:0]   level_q, level_d;

    always_comb begin
        wp_d    = push_i ? wp_q + AddrWidth'(1) : wp_q;
        rp_d    = pop_i  ? rp_q + AddrWidth'(1) : rp_q;
        level_d = level_q + (AddrWidth + 1)'(push_i) - (AddrWidth + 1)'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
        end
    end

    // Contents need no reset: pointers and level make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wp_q] <= wdata_i;
        end
    end

    assign rdata_o      = mem_q[rp_q];
    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign full_o       = (level_q == FullLevel);
    assign empty_o      = (level_q == '0);
endmodule

// File: rtl/hs_elastic_buffer.sv
// Elastic buffer: consumer toward the arf output port, producer toward the
// downstream consumer, with sticky overflow detection and transfer counters.
module hs_elastic_buffer
    import hs_elastic_buffer_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4
) (
    input logic                 clk,
    input logic                 rst,
    hs_elastic_buffer_if.master eb_io
);
    localparam int unsigned AddrWidth = $clog2(Depth);
    // One slot stays free for an ack that may land one cycle after req drops.
    localparam logic [AddrWidth:0] ReqThresh = (AddrWidth + 1)'(Depth - 2);

    logic                 push, pop;
    logic                 full, empty;
    logic [DataWidth-1:0] rdata;
    logic [AddrWidth:0]   level, level_next;

    dn_state_e            dn_state_q, dn_state_d;
    logic                 up_req_q, up_req_d;
    logic [DataWidth-1:0] dn_dout_q, dn_dout_d;
    logic                 overflow_q, overflow_d;
    logic [31:0]          in_count_q, in_count_d;
    logic [31:0]          out_count_q, out_count_d;

    // Acks are honoured whatever up_req currently is; fullness alone decides.
    assign push = eb_io.up_ack & ~full;
    assign pop  = eb_io.dn_req & (dn_state_q == DnIdle) & ~empty;

    hs_fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      (eb_io.up_din),
        .rdata_o      (rdata),
        .level_o      (level),
        .level_next_o (level_next),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_comb begin
        dn_state_d  = DnIdle;
        up_req_d    = (level_next <= ReqThresh);
        dn_dout_d   = dn_dout_q;
        overflow_d  = overflow_q | (eb_io.up_ack & full);
        in_count_d  = push ? in_count_q + 32'd1 : in_count_q;
        out_count_d = out_count_q;
        if (pop) begin
            dn_state_d  = DnAck;
            dn_dout_d   = rdata;
            out_count_d = out_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_state_q  <= DnIdle;
            up_req_q    <= 1'b0;
            dn_dout_q   <= '0;
            overflow_q  <= 1'b0;
            in_count_q  <= '0;
            out_count_q <= '0;
        end else begin
            dn_state_q  <= dn_state_d;
            up_req_q    <= up_req_d;
            dn_dout_q   <= dn_dout_d;
            overflow_q  <= overflow_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
        end
    end

    assign eb_io.up_req    = up_req_q;
    assign eb_io.dn_ack    = (dn_state_q == DnAck);
    assign eb_io.dn_dout   = dn_dout_q;
    assign eb_io.level     = level;
    assign eb_io.overflow  = overflow_q;
    assign eb_io.in_count  = in_count_q;
    assign eb_io.out_count = out_count_q;
endmodule

// File: tb/tb_hs_elastic_buffer.sv
// Bench for hs_elastic_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_hs_elastic_buffer;
    import hs_elastic_buffer_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 4;

    logic clk;
    logic rst;

    hs_elastic_buffer_if #(.DataWidth(DW), .Depth(DP)) bus ();

    hs_elastic_buffer #(
        .DataWidth (DW),
        .Depth     (DP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .eb_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words and the expected outputs.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] got [$];
    bit            mvalid = 0;
    bit            m_ack, m_req, m_ovf, m_pop;
    logic [DW-1:0] m_dout;
    logic [31:0]   m_in, m_out;
    int            lvl;
    int            since_ack;

    always begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ack = 0; m_req = 0; m_ovf = 0; m_dout = '0; m_in = '0; m_out = '0;
            since_ack = 100;
            mvalid = 1;
        end else if (mvalid) begin
            lvl   = mq.size();
            m_pop = bus.dn_req && !m_ack && lvl > 0;
            if (bus.up_ack && lvl == int'(DP)) m_ovf = 1;
            if (m_pop) begin
                m_dout = mq.pop_front();
                m_out  = m_out + 1;
            end
            m_ack = m_pop;
            if (bus.up_ack && lvl < int'(DP)) begin
                mq.push_back(bus.up_din);
                m_in = m_in + 1;
            end
            m_req = (mq.size() <= int'(DP) - 2);
        end
        #1;
        if (mvalid) begin
            chk("up_req", 32'(bus.up_req), 32'(m_req));
            chk("dn_ack", 32'(bus.dn_ack), 32'(m_ack));
            chk("dn_dout", bus.dn_dout, m_dout);
            chk("level", 32'(bus.level), 32'(mq.size()));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("in_count", bus.in_count, m_in);
            chk("out_count", bus.out_count, m_out);
            if (bus.dn_ack === 1'b1) begin
                chk("dn_ack_gap", 32'(since_ack > int'(MinAckGap)), 32'd1);
                got.push_back(bus.dn_dout);
                since_ack = 1;
            end else begin
                since_ack++;
            end
        end
    end

    // Stimulus controls.
    bit            auto_up   = 0;
    bit            seq_data  = 0;
    int            ack_pct   = 100;
    int            dn_mode   = 0;   // 0 idle, 1 always request, 2 random 70 %
    int            limit     = 0;
    int            sent      = 0;
    bit            force_ack = 0;
    logic [DW-1:0] force_val = '0;

    task automatic tick();
        @(negedge clk);
        if (force_ack) begin
            bus.up_ack = 1'b1;
            bus.up_din = force_val;
            force_ack  = 0;
        end else if (auto_up && bus.up_req && !bus.up_ack && sent < limit &&
                     int'($urandom_range(99)) < ack_pct) begin
            bus.up_ack = 1'b1;
            bus.up_din = seq_data ? DW'(sent) : DW'($urandom());
            sent++;
        end else begin
            bus.up_ack = 1'b0;
        end
        case (dn_mode)
            0:       bus.dn_req = 1'b0;
            1:       bus.dn_req = 1'b1;
            default: bus.dn_req = ($urandom_range(99) >= 30);
        endcase
    endtask

    task automatic do_reset();
        auto_up   = 0;
        dn_mode   = 0;
        force_ack = 0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        got.delete();
        sent = 0;
    endtask

    task automatic push_forced(input logic [DW-1:0] val);
        force_ack = 1;
        force_val = val;
        tick();
    endtask

    task automatic wait_out(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (int'(bus.out_count) != target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        bus.up_ack = 1'b0;
        bus.up_din = '0;
        bus.dn_req = 1'b0;

        // Reset values, then idle consumer with an always-acking upstream.
        do_reset();
        chk("rst_up_req", 32'(bus.up_req), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_in_count", bus.in_count, 32'd0);
        auto_up = 1; ack_pct = 100; limit = 1000; seq_data = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_no_dn_ack", 32'(bus.dn_ack), 32'd0);
        end
        chk("idle_level_3_or_4", 32'(bus.level == 3 || bus.level == 4), 32'd1);
        chk("idle_up_req_low", 32'(bus.up_req), 32'd0);
        chk("idle_overflow", 32'(bus.overflow), 32'd0);

        // Stream 0..19 with an always-requesting consumer.
        do_reset();
        auto_up = 1; ack_pct = 100; limit = 20; seq_data = 1; dn_mode = 1;
        wait_out("stream_done", 20, 400);
        chk("stream_in_count", bus.in_count, 32'd20);
        chk("stream_out_count", bus.out_count, 32'd20);
        chk("stream_words", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < got.size()) chk("stream_order", got[i], 32'(i));
        end

        // Fill to depth, reset, and confirm no stale word survives.
        do_reset();
        for (int i = 0; i < 4; i++) push_forced(DW'(32'h50 + i));
        tick();
        chk("fill_level", 32'(bus.level), 32'd4);
        do_reset();
        chk("post_rst_level", 32'(bus.level), 32'd0);
        chk("post_rst_up_req0", 32'(bus.up_req), 32'd0);
        tick();
        chk("post_rst_up_req1", 32'(bus.up_req), 32'd1);
        dn_mode = 1;
        push_forced(32'hCAFE_0001);
        wait_out("post_rst_deliver", 1, 20);
        chk("post_rst_first", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'hCAFE_0001);

        // Ack while full: dropped, sticky overflow, in_count unchanged.
        do_reset();
        for (int i = 0; i < 4; i++) push_forced(DW'(100 + i));
        push_forced(32'hDEAD_BEEF);
        tick();
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_in_count", bus.in_count, 32'd4);
        chk("ovf_level", 32'(bus.level), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        end
        dn_mode = 1;
        wait_out("ovf_drain", 4, 40);
        chk("ovf_drain_words", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("ovf_drain_order", got[i], 32'(100 + i));
        end

        // Full with pop and push on the same edge: pop wins, push is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) push_forced(DW'(200 + i));
        tick();
        dn_mode = 1;
        push_forced(32'h0000_BEEF);
        dn_mode = 0;
        tick();
        chk("simul_dn_ack", 32'(bus.dn_ack), 32'd1);
        chk("simul_dout", bus.dn_dout, 32'd200);
        chk("simul_overflow", 32'(bus.overflow), 32'd1);
        chk("simul_level", 32'(bus.level), 32'd3);

        // Random data, random upstream pacing, 30 % consumer stalls.
        do_reset();
        auto_up = 1; ack_pct = 80; limit = 5000; seq_data = 0; dn_mode = 2;
        wait_out("rand_done", 5000, 60000);
        chk("rand_out_count", bus.out_count, 32'd5000);
        chk("rand_in_count", bus.in_count, 32'd5000);
        chk("rand_overflow", 32'(bus.overflow), 32'd0);
        chk("rand_words", 32'(got.size()), 32'd5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hs_elastic_buffer.md
Name: hs_elastic_buffer

Overview:
- Elastic req/ack buffer placed directly downstream of an arf output port (dout_req_N/dout_ack_N/dout_N), between the graph and its consumer.
- Toward the arf it behaves as a consumer: it drives req and captures data on ack.
- Toward the downstream consumer it behaves as a producer: it pulses ack with data on req.
- An internal FIFO absorbs back-pressure jitter so that consumer fail_rate stalls do not propagate into the graph. Occupancy and transfer counters feed the bench throughput metrics.

Parameters:
- data_width, 32, width of the data word.
- depth, 4, FIFO entries; must be a power of 2 and ≥ 2.
- addr_width, $clog2(depth), derived localparam; not user-set.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- up_req  out  1  request to the upstream arf output node.
- up_ack  in  1  upstream single-cycle ack; up_din is valid in the same cycle.
- up_din  in  data_width  upstream data.
- dn_req  in  1  downstream consumer request.
- dn_ack  out  1  single-cycle ack to the consumer.
- dn_dout  out  data_width  data to the consumer; valid while dn_ack=1, held otherwise.
- level  out  addr_width+1  current FIFO occupancy, 0..depth.
- overflow  out  1  sticky error: an up_ack arrived while the FIFO was full.
- in_count  out  32  number of words accepted from upstream.
- out_count  out  32  number of words delivered downstream.

Behaviour:
- All outputs are registered.
- Reset values: up_req=0, dn_ack=0, dn_dout=0, level=0, overflow=0, in_count=0, out_count=0. Read and write pointers are 0.
- rst asserted mid-operation clears every item above in the next cycle. FIFO contents are discarded, and an in-flight up_ack arriving during rst is ignored.
- Push: on a clk edge with up_ack=1 and level<depth:
  - mem[wp] <= up_din;
  - wp wraps modulo depth;
  - in_count increments.
- up_ack with level==depth: the data is dropped, overflow <= 1 (sticky until rst), and level is unchanged.
- up_ack is accepted regardless of the current up_req value, because the upstream may ack one cycle after req falls.
- up_req <= 1 when (level after this cycle's push/pop) ≤ depth-2; otherwise 0. This keeps one slot reserved for an in-flight ack, so overflow can never occur with a compliant upstream.
- Pop: on a clk edge with dn_req=1, dn_ack=0 and level>0 (level sampled before this cycle's push):
  - dn_ack <= 1;
  - dn_dout <= mem[rp];
  - rp wraps;
  - out_count increments.
  - Otherwise dn_ack <= 0.
- Consequence: dn_ack is never high in two consecutive cycles, so the peak rate is one word per 2 cycles on each side, matching the producer/consumer models.
- Latency: a word captured at edge E can be acked downstream at edge E+1 at the earliest. There is no combinational bypass and no same-edge read of the word being written.
- Simultaneous push and pop: level is unchanged. When level==depth, a pop in the same cycle does NOT make room for that cycle's up_ack; the ack counts as overflow.
- Empty with dn_req=1: dn_ack stays 0 and dn_dout holds its last value.
- Counters wrap modulo 2^32 with no saturation.
- Ordering: strict FIFO. Every accepted word is delivered exactly once.

Decomposition:
- Shared include holds the handshake constants: ack pulse width = 1 and minimum inter-ack gap = 1 cycle. The bench consumer/producer and this block all use it.
- One sub-module, hs_fifo_mem, contains the storage array, the pointers, level, and the full/empty flags.
- hs_elastic_buffer wraps it with the req/ack FSMs, overflow detection and the counters.

Test Plan:
- Reset then idle (dn_req=0, upstream acks on every req): up_req falls once level=depth-1=3; level settles at 3 or 4; overflow=0; dn_ack never asserts.
- Stream of 0,1,2,… with consumer always requesting, 20 words: dn_dout sequence is 0..19 in order; in_count=out_count=20; each dn_ack is one cycle wide with at least one idle cycle between acks.
- Fill to depth=4, then assert rst for 1 cycle: level=0; up_req=0 for the first post-reset cycle, then 1; the next dn_ack delivers the first word sent after reset, not a stale one.
- Forced up_ack while level=4 (up_req=0): overflow=1 and stays 1 through 10 later cycles; the dropped value never appears on dn_dout; in_count is unchanged.
- level=4 with dn_req and up_ack both high on the same edge: pop delivers the oldest word, the push is dropped, overflow=1, and level becomes 3.
- Random consumer stalls at 30 % with 5000 words: output equals the input sequence exactly, overflow=0, and out_count reaches 5000.
